// File: rtl/led_adc_sequencer_if.sv
// Signal bundle between the RED/IR LED/ADC sequencer (master) and the finger-clip
// front end / FIR filters (slave).
interface led_adc_sequencer_if;
  // ADC_Start is a one-cycle request; ADC_Data is valid only in cycles where
  // ADC_Done=1. RED_Valid/IR_Valid are one-cycle strobes with no back-pressure:
  // the matching *_ADC_Value changes in exactly the cycle its strobe is high
  // and is held until the next strobe.
  logic       Enable;
  logic       ADC_Done;
  logic [7:0] ADC_Data;
  logic       LED_RED;
  logic       LED_IR;
  logic       ADC_Start;
  logic [7:0] RED_ADC_Value;
  logic [7:0] IR_ADC_Value;
  logic       RED_Valid;
  logic       IR_Valid;
  logic       Err_Timeout;

  modport master (
    input  Enable, ADC_Done, ADC_Data,
    output LED_RED, LED_IR, ADC_Start, RED_ADC_Value, IR_ADC_Value,
           RED_Valid, IR_Valid, Err_Timeout
  );

  modport slave (
    output Enable, ADC_Done, ADC_Data,
    input  LED_RED, LED_IR, ADC_Start, RED_ADC_Value, IR_ADC_Value,
           RED_Valid, IR_Valid, Err_Timeout
  );
endinterface

// File: rtl/led_adc_sequencer.sv
// Alternating red/IR LED drive with one ADC conversion per phase.
// Optional macro LED_DEADTIME_EN: both LEDs off for the first DEAD_CYC cycles of every phase.
module led_adc_sequencer #(
  parameter int PHASE_CYC       = 50000,
  parameter int SETTLE_CYC      = 10000,
  parameter int ADC_TIMEOUT_CYC = 1000,
  parameter int DEAD_CYC        = 100
) (
  input  logic                       CLK_Filter,
  input  logic                       rst_n,
  led_adc_sequencer_if.master        bus,
  output logic [1:0]                 dbg_state,
  output logic                       dbg_phase,
  output logic                       dbg_cfg_ok
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CONVERT = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam int PC_W = $clog2(PHASE_CYC + 1);
  localparam int TC_W = $clog2(ADC_TIMEOUT_CYC + 1);

  localparam logic [PC_W-1:0] PC_LAST        = PC_W'(PHASE_CYC - 1);
  localparam logic [PC_W-1:0] PC_SETTLE_LAST = PC_W'(SETTLE_CYC - 1);
  localparam logic [TC_W-1:0] TC_LAST        = TC_W'(ADC_TIMEOUT_CYC - 1);

  // A conversion must always resolve before the phase ends, and the LED must be
  // on before the ADC is started.
  localparam logic CFG_OK = ((SETTLE_CYC + 1 + ADC_TIMEOUT_CYC) < PHASE_CYC) &&
                            (DEAD_CYC < SETTLE_CYC) && (SETTLE_CYC >= 1) &&
                            (ADC_TIMEOUT_CYC >= 1);

`ifdef LED_DEADTIME_EN
  localparam logic            LED_AT_START = (DEAD_CYC == 0);
  localparam logic [PC_W-1:0] PC_DEAD_LAST = PC_W'(DEAD_CYC - 1);
`else
  localparam logic            LED_AT_START = 1'b1;
`endif

  localparam logic PH_RED = 1'b0;

  state_t          state;
  logic            phase;
  logic [PC_W-1:0] pc;
  logic [TC_W-1:0] tc;
  logic            led_red_q;
  logic            led_ir_q;
  logic            adc_start_q;
  logic [7:0]      red_val_q;
  logic [7:0]      ir_val_q;
  logic            red_vld_q;
  logic            ir_vld_q;
  logic            err_q;

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      phase       <= PH_RED;
      pc          <= '0;
      tc          <= '0;
      led_red_q   <= 1'b0;
      led_ir_q    <= 1'b0;
      adc_start_q <= 1'b0;
      red_val_q   <= '0;
      ir_val_q    <= '0;
      red_vld_q   <= 1'b0;
      ir_vld_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      adc_start_q <= 1'b0;
      red_vld_q   <= 1'b0;
      ir_vld_q    <= 1'b0;
      if (!bus.Enable) begin
        // Values and the sticky error survive a disable; an open conversion is dropped.
        state     <= IDLE;
        phase     <= PH_RED;
        pc        <= '0;
        tc        <= '0;
        led_red_q <= 1'b0;
        led_ir_q  <= 1'b0;
      end else if (state == IDLE) begin
        state     <= SETTLE;
        phase     <= PH_RED;
        pc        <= '0;
        tc        <= '0;
        led_red_q <= LED_AT_START;
        led_ir_q  <= 1'b0;
      end else begin
        if (state == CONVERT) begin
          if (bus.ADC_Done) begin
            if (phase == PH_RED) begin
              red_val_q <= bus.ADC_Data;
              red_vld_q <= 1'b1;
            end else begin
              ir_val_q  <= bus.ADC_Data;
              ir_vld_q  <= 1'b1;
            end
          end else if (tc == TC_LAST || pc == PC_LAST) begin
            err_q <= 1'b1;
          end
        end

        if (pc == PC_LAST) begin
          // phase is the outgoing phase here, so the new red drive equals phase.
          phase     <= ~phase;
          pc        <= '0;
          tc        <= '0;
          state     <= SETTLE;
          led_red_q <= phase & LED_AT_START;
          led_ir_q  <= ~phase & LED_AT_START;
        end else begin
          pc <= pc + 1'b1;
          case (state)
            SETTLE: begin
              if (pc == PC_SETTLE_LAST) begin
                state       <= CONVERT;
                adc_start_q <= 1'b1;
                tc          <= '0;
              end
            end
            CONVERT: begin
              if (bus.ADC_Done || tc == TC_LAST) state <= HOLD;
              else                               tc    <= tc + 1'b1;
            end
            default: ;
          endcase
`ifdef LED_DEADTIME_EN
          if (DEAD_CYC > 0 && pc == PC_DEAD_LAST) begin
            led_red_q <= (phase == PH_RED);
            led_ir_q  <= (phase != PH_RED);
          end
`endif
        end
      end
    end
  end

  assign bus.LED_RED       = led_red_q;
  assign bus.LED_IR        = led_ir_q;
  assign bus.ADC_Start     = adc_start_q;
  assign bus.RED_ADC_Value = red_val_q;
  assign bus.IR_ADC_Value  = ir_val_q;
  assign bus.RED_Valid     = red_vld_q;
  assign bus.IR_Valid      = ir_vld_q;
  assign bus.Err_Timeout   = err_q;

  assign dbg_state  = state;
  assign dbg_phase  = phase;
  assign dbg_cfg_ok = CFG_OK;

endmodule
